quiz_round_ctrl: RTL and testbench
==================================

// Module: quiz_round_ctrl
// PURPOSE
//  Round sequencer for the Morse quiz. Picks a target symbol from the free-running refresh count,
//  waits for the decoded answer or a timeout, and grades it. Drives the 2-bit check code into the
//  BCD score counter and tracks misses until game over.
//  Sits between the decoder/refresh/divider blocks and counter/selectLed.
// PARAMETERS
//  NUM_SYMBOLS  36  symbol alphabet size; legal codes 0..NUM_SYMBOLS-1 (6-bit)
//  RAND_W       20  width of rand_in (refresh counter)
//  ROUND_SECS   10  answer window in tick_1s pulses, 1..63
//  SHOW_SECS    2   result display hold in tick_1s pulses, 1..15
//  MAX_MISSES   3   wrong/timeout rounds before game over, 1..7
// PORTS
//  clock         in   1       system clock (100 MHz)
//  clear         in   1       reset, asynchronous, active-low
//  tick_1s       in   1       1-cycle pulse per second from the divider
//  start         in   1       1-cycle start pulse (debounced button)
//  rand_in       in   RAND_W  free-running refresh count
//  ans_valid     in   1       1-cycle pulse: decoder finished a symbol
//  ans_code      in   6       decoded symbol, valid with ans_valid
//  letter_q      out  6       current target symbol (to display/LED)
//  new_letter    out  1       1-cycle pulse when letter_q is updated
//  check         out  2       11 CORRECT, 00 WRONG, 01 STAY; non-01 for exactly 1 cycle per round
//  secs_left     out  6       remaining seconds in the answer window
//  misses        out  3       miss count this game
//  round_active  out  1       high in WAIT
//  game_over     out  1       high in OVER
// BEHAVIOUR
//  Reset (clear=0, async): state IDLE, letter_q=0, new_letter=0, check=01, secs_left=0,
//   misses=0, round_active=0, game_over=0, prev symbol=0.
//  All outputs are registered. States IDLE, ISSUE, WAIT, SHOW, OVER.
//  IDLE:  start -> ISSUE; clear misses.
//  ISSUE (1 cycle):
//   - pick = rand_in % NUM_SYMBOLS.
//   - If pick == prev symbol: pick = (pick+1) % NUM_SYMBOLS, so no immediate repeat.
//   - Next cycle: letter_q=pick, prev=pick, new_letter=1, secs_left=ROUND_SECS. -> WAIT.
//  WAIT:
//   - tick_1s decrements secs_left.
//   - ans_valid: check=11 if ans_code==letter_q, else 00 and misses+1. -> SHOW.
//   - tick_1s with secs_left==1: check=00, misses+1. -> SHOW.
//   - ans_valid and expiring tick in the same cycle: the answer wins.
//  SHOW:
//   - check returns to 01 the cycle after grading. Hold SHOW_SECS ticks; letter_q held.
//   - Answers arriving in SHOW are ignored.
//   - Exit: misses==MAX_MISSES -> OVER, else -> ISSUE.
//   - Hold count starts at the first full tick after entry, so a tick in the grading cycle does not count.
//  OVER: game_over=1. start -> ISSUE with misses cleared. A start pulse in any other state is ignored.
//  Arithmetic and widths:
//   - misses saturates at MAX_MISSES. secs_left never underflows.
//   - % uses full RAND_W; the result is truncated to 6 bits.
//  Latency: ans_valid -> check registered at the next edge (1 cycle).
//   start -> new_letter is 2 cycles.
//  clear asserted mid-round: immediate return to reset values. No check pulse is emitted.
// STRUCTURE
//  Shared include quiz_defs.vh:
//   - CHK_CORRECT=2'b11, CHK_WRONG=2'b00, CHK_STAY=2'b01.
//   - State encodings (3-bit) and NUM_SYMBOLS default.
//  One sub-module: sec_down_timer.
//   - Loads a value and decrements on tick_1s; expires when count==1 && tick.
//   - Async active-low clear. Used for both the WAIT and SHOW windows.
//  FSM and grading live in quiz_round_ctrl.
// TESTING
//  1. Reset mid-WAIT (secs_left=7) -> all outputs at reset values in the same cycle; check=01.
//  2. start, rand_in=40 -> new_letter 2 cycles later with letter_q=4, secs_left=10.
//     ans_code=4 valid -> single-cycle check=11, misses=0.
//  3. Wrong answer: letter_q=4, ans_code=5 -> check=00 for 1 cycle, misses=1. A second ans_valid in SHOW is ignored.
//  4. Timeout: no answer, 10 ticks -> check=00 on the 10th tick, misses+1.
//     Tick and a correct ans_valid in the same cycle -> check=11.
//  5. No-repeat: previous 4, rand_in=76 (76%36=4) -> letter_q=5. prev 35, rand_in=35 -> letter_q=0.
//  6. Three misses -> game_over=1 after SHOW_SECS ticks; start ignored in WAIT.
//     start in OVER -> misses=0, new round issued.

Source files
------------

// File: rtl/quiz_round_ctrl_pkg.sv
// Shared definitions for the Morse quiz round sequencer.
//   - Check codes driven into the BCD score counter.
//   - FSM state encoding (3-bit).
//   - Default alphabet size and a symbol wrap helper.
package quiz_round_ctrl_pkg;

    localparam logic [1:0] CHK_CORRECT = 2'b11;
    localparam logic [1:0] CHK_WRONG   = 2'b00;
    localparam logic [1:0] CHK_STAY    = 2'b01;

    localparam int unsigned NUM_SYMBOLS_DEF = 36;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StIssue = 3'd1,
        StWait  = 3'd2,
        StShow  = 3'd3,
        StOver  = 3'd4
    } state_e;

    // Next symbol in the alphabet, wrapping back to 0 after num-1.
    function automatic logic [5:0] bump_symbol(input logic [5:0] sym, input int unsigned num);
        if ({26'd0, sym} + 32'd1 >= num) begin
            return 6'd0;
        end
        return sym + 6'd1;
    endfunction

endpackage

// File: rtl/sec_down_timer.sv
// Seconds down-counter for the quiz answer and result-display windows.
//   clk_i      system clock
//   rst_ni     asynchronous active-low clear
//   load_i     load load_val_i (wins over tick_i)
//   load_val_i start value of the window
//   tick_i     1-second pulse; decrements, never below zero
//   count_o    remaining seconds
//   expire_o   combinational: last second elapses this cycle (count==1 && tick)
module sec_down_timer #(
    parameter int unsigned W = 6
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         tick_i,
    output logic [W-1:0] count_o,
    output logic         expire_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign expire_o = tick_i && (count_q == W'(1));

endmodule

// File: rtl/quiz_round_ctrl.sv
// Round sequencer for the Morse quiz: issues a target symbol, waits for an answer or a
// timeout, grades it, holds the result on display, and counts misses until game over.
//   clock, clear           system clock, asynchronous active-low reset
//   tick_1s, start         1-second pulse, debounced start pulse
//   rand_in                free-running refresh count used as the random source
//   ans_valid, ans_code    decoded answer strobe and symbol
//   letter_q, new_letter   current target and its update strobe
//   check                  11 correct / 00 wrong / 01 stay (one non-01 cycle per round)
//   secs_left, misses      remaining answer seconds, misses this game
//   round_active, game_over high in WAIT / OVER
module quiz_round_ctrl
    import quiz_round_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SYMBOLS = NUM_SYMBOLS_DEF,
    parameter int unsigned RAND_W      = 20,
    parameter int unsigned ROUND_SECS  = 10,
    parameter int unsigned SHOW_SECS   = 2,
    parameter int unsigned MAX_MISSES  = 3
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              tick_1s,
    input  logic              start,
    input  logic [RAND_W-1:0] rand_in,
    input  logic              ans_valid,
    input  logic [5:0]        ans_code,
    output logic [5:0]        letter_q,
    output logic              new_letter,
    output logic [1:0]        check,
    output logic [5:0]        secs_left,
    output logic [2:0]        misses,
    output logic              round_active,
    output logic              game_over
);

    localparam logic [2:0] MaxMiss   = 3'(MAX_MISSES);
    localparam logic [5:0] RoundSecs = 6'(ROUND_SECS);
    localparam logic [5:0] ShowSecs  = 6'(SHOW_SECS);

    state_e     state_q, state_d;
    logic [5:0] target_q, target_d;
    logic       new_letter_q, new_letter_d;
    logic [1:0] check_q, check_d;
    logic [2:0] misses_q, misses_d;
    logic       round_active_q, game_over_q;

    logic       grade;
    logic [5:0] pick_raw, pick;
    logic [2:0] misses_inc;
    logic [5:0] wait_count, show_count;
    logic       wait_expire, show_expire;

    // The current target doubles as the "previous symbol" for the no-repeat rule.
    always_comb begin
        pick_raw = 6'(rand_in % RAND_W'(NUM_SYMBOLS));
        pick     = (pick_raw == target_q) ? bump_symbol(pick_raw, NUM_SYMBOLS) : pick_raw;
    end

    assign misses_inc = (misses_q >= MaxMiss) ? MaxMiss : misses_q + 3'd1;

    sec_down_timer #(.W(6)) u_wait_timer (
        .clk_i      (clock),
        .rst_ni     (clear),
        .load_i     (state_q == StIssue),
        .load_val_i (RoundSecs),
        .tick_i     (tick_1s && (state_q == StWait)),
        .count_o    (wait_count),
        .expire_o   (wait_expire)
    );

    // Loaded on the grading edge and only ticked in SHOW, so a tick in the grading cycle
    // does not shorten the display hold.
    sec_down_timer #(.W(6)) u_show_timer (
        .clk_i      (clock),
        .rst_ni     (clear),
        .load_i     (grade),
        .load_val_i (ShowSecs),
        .tick_i     (tick_1s && (state_q == StShow)),
        .count_o    (show_count),
        .expire_o   (show_expire)
    );

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        new_letter_d = 1'b0;
        check_d      = CHK_STAY;
        misses_d     = misses_q;
        grade        = 1'b0;
        unique case (state_q)
            StIdle, StOver: begin
                if (start) begin
                    state_d  = StIssue;
                    misses_d = 3'd0;
                end
            end
            StIssue: begin
                target_d     = pick;
                new_letter_d = 1'b1;
                state_d      = StWait;
            end
            StWait: begin
                // An answer beats an expiring tick in the same cycle.
                if (ans_valid) begin
                    grade   = 1'b1;
                    state_d = StShow;
                    if (ans_code == target_q) begin
                        check_d = CHK_CORRECT;
                    end else begin
                        check_d  = CHK_WRONG;
                        misses_d = misses_inc;
                    end
                end else if (wait_expire) begin
                    grade    = 1'b1;
                    state_d  = StShow;
                    check_d  = CHK_WRONG;
                    misses_d = misses_inc;
                end
            end
            StShow: begin
                // Zero count is unreachable with a legal hold length; exit rather than hang.
                if (show_expire || (show_count == 6'd0)) begin
                    state_d = (misses_q >= MaxMiss) ? StOver : StIssue;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q        <= StIdle;
            target_q       <= 6'd0;
            new_letter_q   <= 1'b0;
            check_q        <= CHK_STAY;
            misses_q       <= 3'd0;
            round_active_q <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            new_letter_q   <= new_letter_d;
            check_q        <= check_d;
            misses_q       <= misses_d;
            round_active_q <= (state_d == StWait);
            game_over_q    <= (state_d == StOver);
        end
    end

    assign letter_q     = target_q;
    assign new_letter   = new_letter_q;
    assign check        = check_q;
    assign secs_left    = wait_count;
    assign misses       = misses_q;
    assign round_active = round_active_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Scoreboard bench for quiz_round_ctrl: stimulus tasks push expected letter/grade events,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_quiz_round_ctrl;

    localparam int NSYM  = 36;
    localparam int ROUND = 10;
    localparam int SHOW  = 2;
    localparam int MAXM  = 3;

    logic        clock, clear, tick_1s, start, ans_valid;
    logic [19:0] rand_in;
    logic [5:0]  ans_code;
    logic [5:0]  letter_q, secs_left;
    logic        new_letter, round_active, game_over;
    logic [1:0]  check;
    logic [2:0]  misses;

    quiz_round_ctrl #(
        .NUM_SYMBOLS (NSYM),
        .RAND_W      (20),
        .ROUND_SECS  (ROUND),
        .SHOW_SECS   (SHOW),
        .MAX_MISSES  (MAXM)
    ) dut (
        .clock        (clock),
        .clear        (clear),
        .tick_1s      (tick_1s),
        .start        (start),
        .rand_in      (rand_in),
        .ans_valid    (ans_valid),
        .ans_code     (ans_code),
        .letter_q     (letter_q),
        .new_letter   (new_letter),
        .check        (check),
        .secs_left    (secs_left),
        .misses       (misses),
        .round_active (round_active),
        .game_over    (game_over)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    int exp_letter[$], exp_lmiss[$], exp_check[$], exp_gmiss[$];

    // Reference model: previous/current target and misses this game.
    int m_prev, m_misses;

    task automatic cmp(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
        end
    endtask

    function automatic int pick_of(input int r);
        int p;
        p = r % NSYM;
        if (p == m_prev) p = (p + 1) % NSYM;
        return p;
    endfunction

    function automatic int rand_wrong();
        if ($urandom_range(0, 3) == 0) return $urandom_range(NSYM, 63);
        return (m_prev + 1 + $urandom_range(0, NSYM - 2)) % NSYM;
    endfunction

    function automatic void miss_up();
        if (m_misses < MAXM) m_misses++;
    endfunction

    // Monitor: every new_letter and every non-STAY check must match the next expectation.
    always @(negedge clock) begin
        int l, m;
        if (clear) begin
            if (new_letter) begin
                if (exp_letter.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_new_letter actual=%0d required=none", letter_q);
                end else begin
                    l = exp_letter.pop_front();
                    m = exp_lmiss.pop_front();
                    cmp("letter", letter_q, l);
                    cmp("secs_at_issue", secs_left, ROUND);
                    cmp("misses_at_issue", misses, m);
                end
            end
            if (check != 2'b01) begin
                if (exp_check.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_check actual=%0d required=1", check);
                end else begin
                    l = exp_check.pop_front();
                    m = exp_gmiss.pop_front();
                    cmp("check", check, l);
                    cmp("misses_at_grade", misses, m);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic pulse_tick();
        tick_1s = 1'b1;
        cyc();
        tick_1s = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        cmp({tag, "_letter"}, letter_q, 0);
        cmp({tag, "_new_letter"}, new_letter, 0);
        cmp({tag, "_check"}, check, 1);
        cmp({tag, "_secs_left"}, secs_left, 0);
        cmp({tag, "_misses"}, misses, 0);
        cmp({tag, "_round_active"}, round_active, 0);
        cmp({tag, "_game_over"}, game_over, 0);
    endtask

    // From IDLE or OVER: start pulse, then letter appears two edges later.
    task automatic start_game(input int r);
        int p;
        m_misses = 0;
        p = pick_of(r);
        exp_letter.push_back(p);
        exp_lmiss.push_back(0);
        m_prev  = p;
        rand_in = 20'(r);
        start   = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cmp("start_latency", new_letter, 1);
        cmp("round_active_wait", round_active, 1);
        cmp("game_over_cleared", game_over, 0);
    endtask

    // kind: 0 correct, 1 wrong, 2 timeout, 3 expiring tick with correct answer.
    task automatic grade_round(input int kind, input int pre, input int wcode, input bit siw);
        int code, expc;
        if (kind <= 1) begin
            for (int i = 0; i < pre; i++) begin
                pulse_tick();
                idle($urandom_range(0, 2));
            end
            cmp("secs_left_count", secs_left, ROUND - pre);
            if (siw) begin
                start = 1'b1;
                cyc();
                start = 1'b0;
            end
            if (kind == 0) code = m_prev;
            else if (wcode >= 0) code = wcode;
            else code = rand_wrong();
            expc = (code == m_prev) ? 3 : 0;
            if (expc == 0) miss_up();
            exp_check.push_back(expc);
            exp_gmiss.push_back(m_misses);
            ans_valid = 1'b1;
            ans_code  = 6'(code);
            cyc();
            ans_valid = 1'b0;
            cmp("grade_latency", check, expc);
        end else begin
            for (int i = 0; i < ROUND - 1; i++) begin
                pulse_tick();
                idle($urandom_range(0, 2));
            end
            cmp("secs_before_expiry", secs_left, 1);
            if (kind == 2) begin
                miss_up();
                exp_check.push_back(0);
                exp_gmiss.push_back(m_misses);
                pulse_tick();
                cmp("timeout_grade", check, 0);
                cmp("secs_left_floor", secs_left, 0);
            end else begin
                exp_check.push_back(3);
                exp_gmiss.push_back(m_misses);
                tick_1s   = 1'b1;
                ans_valid = 1'b1;
                ans_code  = 6'(m_prev);
                cyc();
                tick_1s   = 1'b0;
                ans_valid = 1'b0;
                cmp("collision_grade", check, 3);
            end
        end
    endtask

    // Called in the first SHOW cycle; returns 1 when the game ended.
    task automatic show_phase(input int r_next, input bit spurious, output bit over);
        int p;
        cyc();
        cmp("check_back_to_stay", check, 1);
        if (spurious) begin
            ans_valid = 1'b1;
            ans_code  = 6'(m_prev);
            cyc();
            ans_valid = 1'b0;
        end
        for (int i = 0; i < SHOW - 1; i++) begin
            pulse_tick();
            idle($urandom_range(0, 2));
        end
        cmp("letter_held_in_show", letter_q, m_prev);
        over = (m_misses >= MAXM);
        if (!over) begin
            p = pick_of(r_next);
            exp_letter.push_back(p);
            exp_lmiss.push_back(m_misses);
            m_prev  = p;
            rand_in = 20'(r_next);
        end
        pulse_tick();
        if (over) begin
            cmp("game_over_set", game_over, 1);
            cmp("misses_saturated", misses, MAXM);
            cmp("round_inactive_over", round_active, 0);
        end else begin
            cyc();
            cmp("auto_issue", new_letter, 1);
        end
    endtask

    function automatic int rnd20();
        return int'($urandom_range(0, 20'hFFFFF));
    endfunction

    initial begin
        bit over;
        int rounds, kind;
        clear = 1'b0; tick_1s = 1'b0; start = 1'b0; ans_valid = 1'b0;
        rand_in = '0; ans_code = '0;
        m_prev = 0; m_misses = 0;
        idle(3);
        check_reset_values("reset");
        clear = 1'b1;
        idle(2);

        // Directed game: letter 4, repeat-avoid 4->5, 35, repeat-avoid 35->0, then three misses.
        start_game(40);
        grade_round(0, 0, -1, 1'b0);
        show_phase(76, 1'b1, over);
        cmp("no_repeat_bump", letter_q, 5);
        grade_round(1, 2, 6, 1'b0);
        show_phase(35, 1'b1, over);
        grade_round(2, 0, -1, 1'b0);
        show_phase(35, 1'b0, over);
        cmp("no_repeat_wrap", letter_q, 0);
        grade_round(3, 0, -1, 1'b0);
        show_phase(rnd20(), 1'b0, over);
        grade_round(1, 5, -1, 1'b1);
        show_phase(rnd20(), 1'b0, over);
        cmp("directed_game_over", int'(over), 1);
        idle(2);

        // Restart from OVER, then reset in the middle of the answer window.
        start_game(rnd20());
        cmp("misses_restart", misses, 0);
        for (int i = 0; i < 3; i++) pulse_tick();
        cmp("secs_left_7", secs_left, 7);
        #2;
        clear = 1'b0;
        #1;
        check_reset_values("midreset");
        m_prev = 0; m_misses = 0;
        @(posedge clock);
        #1;
        clear = 1'b1;
        cyc();
        cmp("no_pulse_after_reset", check, 1);

        // Randomised games.
        for (int g = 0; g < 6; g++) begin
            start_game(rnd20());
            over   = 1'b0;
            rounds = 0;
            while (!over && rounds < 20) begin
                kind = (rounds >= 12) ? 1 : int'($urandom_range(0, 3));
                grade_round(kind, $urandom_range(0, ROUND - 1), -1, $urandom_range(0, 3) == 0);
                show_phase(rnd20(), $urandom_range(0, 1) == 1, over);
                rounds++;
            end
            idle($urandom_range(1, 4));
        end

        idle(5);
        cmp("letter_queue_drained", exp_letter.size(), 0);
        cmp("check_queue_drained", exp_check.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
